// File: rtl/mc_control_fsm.sv
// Multicycle control unit: Moore FSM sequencing a shared ALU and
// unified memory across FETCH/DECODE/EXEC/WB cycles per instruction.
module mc_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic       instr_done,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t     cur, nxt;
   logic       pcupdate, branch, legal;
   logic       irw, regw, memw, done;
   logic [1:0] aluop, imm;

   // State register; reset returns to FETCH.
   always_ff @(posedge clk) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   // Next-state and Moore output decode.
   always_comb begin
      nxt       = S_FETCH;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      legal     = 1'b1;
      irw       = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      done      = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      aluop     = 2'b00;
      case (cur)
         S_FETCH: begin
            nxt       = S_DECODE;
            irw       = 1'b1;
            pcupdate  = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_JAL:       nxt = S_JAL;
               OP_BEQ:       nxt = S_BEQ;
               default: begin
                  nxt  = S_FETCH;
                  done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            if (op == OP_LW)      nxt = S_MEMREAD;
            else if (op == OP_SW) nxt = S_MEMWRITE;
            else                  nxt = S_FETCH;
         end
         S_MEMREAD: begin
            nxt    = S_MEMWB;
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
            done      = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
            done   = 1'b1;
         end
         S_EXECR: begin
            nxt     = S_ALUWB;
            ALUSrcA = 2'b10;
            aluop   = 2'b10;
         end
         S_EXECI: begin
            nxt     = S_ALUWB;
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            regw = 1'b1;
            done = 1'b1;
         end
         S_JAL: begin
            nxt      = S_ALUWB;
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            aluop   = 2'b01;
            branch  = 1'b1;
            done    = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // ALU decoder: ALUOp selects add/sub or funct3-driven operation.
   always_comb begin
      ALUControl = 3'b000;
      case (aluop)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

   // Immediate format straight from the opcode.
   always_comb begin
      imm = 2'b00;
      case (op)
         OP_SW:   imm = 2'b01;
         OP_BEQ:  imm = 2'b10;
         OP_JAL:  imm = 2'b11;
         default: imm = 2'b00;
      endcase
   end

   assign ImmSrc     = legal ? imm : 2'b00;
   assign PCWrite    = ~reset & (pcupdate | (branch & zero));
   assign IRWrite    = ~reset & irw;
   assign RegWrite   = ~reset & regw;
   assign MemWrite   = ~reset & memw;
   assign instr_done = ~reset & done;
   assign state      = cur;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction state sequences and a
// per-state control table, checked every cycle with directed+random ops.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;
   int seq[$];

   typedef struct packed {
      logic       pcu, br, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, ao;
   } ctl_t;

   ctl_t ctl_tab [0:10];

   always #5 clk = ~clk;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
      .instr_done(instr_done), .state(state)
   );

   function automatic ctl_t mk(bit pcu, bit br, bit adr, bit mw,
                               bit irw, bit rw, logic [1:0] rs,
                               logic [1:0] sa, logic [1:0] sb,
                               logic [1:0] ao);
      return {pcu, br, adr, mw, irw, rw, rs, sa, sb, ao};
   endfunction

   // Visited states of one instruction, FETCH through its last state.
   task automatic build_seq(input logic [6:0] o);
      case (o)
         7'b0000011: seq = {0, 1, 2, 3, 4};
         7'b0100011: seq = {0, 1, 2, 5};
         7'b0110011: seq = {0, 1, 6, 7};
         7'b0010011: seq = {0, 1, 8, 7};
         7'b1101111: seq = {0, 1, 9, 7};
         7'b1100011: seq = {0, 1, 10};
         default:    seq = {0, 1};
      endcase
   endtask

   function automatic logic [1:0] imm_exp(logic [6:0] o);
      if (o == 7'b0100011) return 2'd1;
      if (o == 7'b1100011) return 2'd2;
      if (o == 7'b1101111) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [2:0] alu_exp(logic [1:0] ao, logic [6:0] o,
                                          logic [2:0] f3, logic f7);
      if (ao == 2'd1) return 3'd1;
      if (ao != 2'd2) return 3'd0;
      if (f3 == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
      if (f3 == 3'd2) return 3'd5;
      if (f3 == 3'd6) return 3'd3;
      if (f3 == 3'd7) return 3'd2;
      return 3'd0;
   endfunction

   task automatic chk(input string tag, input logic [3:0] got,
                      input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s st=%0d got=%0h exp=%0h", tag, state, got, exp);
      end
   endtask

   task automatic check_step(input int es, input bit last);
      ctl_t c;
      logic g;
      c = ctl_tab[es];
      g = ~reset;
      chk("state", state, 4'(es));
      chk("PCWrite", 4'(PCWrite), 4'(g & (c.pcu | (c.br & zero))));
      chk("IRWrite", 4'(IRWrite), 4'(g & c.irw));
      chk("RegWrite", 4'(RegWrite), 4'(g & c.rw));
      chk("MemWrite", 4'(MemWrite), 4'(g & c.mw));
      chk("instr_done", 4'(instr_done), 4'(g & last));
      chk("AdrSrc", 4'(AdrSrc), 4'(c.adr));
      chk("ResultSrc", 4'(ResultSrc), 4'(c.rs));
      chk("ALUSrcA", 4'(ALUSrcA), 4'(c.sa));
      chk("ALUSrcB", 4'(ALUSrcB), 4'(c.sb));
      chk("ImmSrc", 4'(ImmSrc), 4'(imm_exp(op)));
      chk("ALUControl", 4'(ALUControl),
          4'(alu_exp(c.ao, op, funct3, funct7b5)));
   endtask

   // zm: 0/1 hold zero at that value, 2 randomise it every cycle.
   // abort_at >= 0 raises reset in that step of the instruction.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input int zm,
                            input int abort_at);
      build_seq(o);
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         if (i == 0) begin
            reset    = 1'b0;
            op       = o;
            funct3   = f3;
            funct7b5 = f7;
         end
         zero = (zm == 2) ? 1'($urandom % 2) : 1'(zm);
         if (i == abort_at) reset = 1'b1;
         #1;
         check_step(seq[i], i == seq.size() - 1);
         if (i == abort_at) return;
      end
   endtask

   task automatic reset_step();
      @(negedge clk);
      reset = 1'b1;
      zero  = 1'($urandom % 2);
      #1;
      check_step(0, 1'b0);
   endtask

   initial begin
      logic [6:0] ops [0:6];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1101111, 7'b1100011, 7'b1111111};
      ctl_tab[0]  = mk(1, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 2'd0);
      ctl_tab[1]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0);
      ctl_tab[2]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0);
      ctl_tab[3]  = mk(0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
      ctl_tab[4]  = mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0);
      ctl_tab[5]  = mk(0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0);
      ctl_tab[6]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2);
      ctl_tab[7]  = mk(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
      ctl_tab[8]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd2);
      ctl_tab[9]  = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0);
      ctl_tab[10] = mk(0, 1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1);

      reset    = 1'b1;
      op       = 7'd0;
      funct3   = 3'd0;
      funct7b5 = 1'b0;
      zero     = 1'b0;

      reset_step();
      reset_step();

      run_instr(7'b0000011, 3'd2, 1'b0, 2, -1);
      run_instr(7'b0000011, 3'd2, 1'b0, 2, 3);
      reset_step();
      run_instr(7'b0100011, 3'd2, 1'b0, 2, -1);
      run_instr(7'b0110011, 3'd0, 1'b1, 2, -1);
      run_instr(7'b0110011, 3'd0, 1'b0, 2, -1);
      run_instr(7'b0110011, 3'd6, 1'b0, 2, -1);
      run_instr(7'b0110011, 3'd2, 1'b0, 2, -1);
      run_instr(7'b0110011, 3'd7, 1'b1, 2, -1);
      run_instr(7'b0010011, 3'd0, 1'b1, 2, -1);
      run_instr(7'b1100011, 3'd0, 1'b0, 1, -1);
      run_instr(7'b1100011, 3'd0, 1'b0, 0, -1);
      run_instr(7'b1101111, 3'd0, 1'b0, 2, -1);
      run_instr(7'b1111111, 3'd0, 1'b0, 2, -1);

      for (int n = 0; n < 80; n++) begin
         logic [6:0] o;
         o = ops[$urandom_range(0, 6)];
         if (o == 7'b1111111) o = 7'($urandom);
         run_instr(o, 3'($urandom), 1'($urandom % 2), 2,
                   ($urandom % 16 == 0) ? int'($urandom_range(0, 2)) : -1);
         if (reset) reset_step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
